// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the main-memory arbiter: FSM encoding, owner encoding,
// default latency and the round-robin owner selection.
package mem_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic OWN_ICACHE = 1'b0;
    localparam logic OWN_DCACHE = 1'b1;

    localparam int DEFAULT_MEM_LATENCY = 4;

    // A tie goes to whichever requester was not granted last.
    function automatic logic pick_owner(input logic pet_i, input logic pet_d,
                                        input logic last_grant);
        logic owner;
        if (pet_i && pet_d) begin
            owner = (last_grant == OWN_ICACHE) ? OWN_DCACHE : OWN_ICACHE;
        end else if (pet_d) begin
            owner = OWN_DCACHE;
        end else begin
            owner = OWN_ICACHE;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_arbiter_enreg.sv
// Enable/reset register: clears on synchronous reset, loads when enabled.
module mem_arbiter_enreg #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Hold register with reset priority over load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared main-memory port between instruction and
// data caches: round-robin grant, fixed-latency count, one-cycle ready pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int addr_width       = 16,
    parameter int cache_line_width = 256,
    parameter int mem_latency      = DEFAULT_MEM_LATENCY
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        petitionFromIcache,
    input  logic [addr_width-1:0]       addrFromIcache,
    input  logic                        petitionFromDcache,
    input  logic [addr_width-1:0]       addrFromDcache,
    input  logic                        writeFromDcache,
    input  logic [cache_line_width-1:0] lineFromDcache,
    output logic                        memServiceReadyIcache,
    output logic                        memServiceReadyDcache,
    output logic [addr_width-1:0]       memAddr,
    output logic                        memRead,
    output logic                        memWrite,
    output logic [cache_line_width-1:0] memWriteLine,
    output logic                        busy
);

    localparam logic [3:0] LAT_LAST = 4'(mem_latency - 1);

    logic [0:0] r_state;
    logic [3:0] r_cnt;
    logic       r_last_grant;
    logic       r_owner;
    logic       r_wflag;

    logic                        w_grant;
    logic                        w_owner_next;
    logic                        w_wflag_next;
    logic                        w_done;
    logic                        w_busy;
    logic [addr_width-1:0]       w_addr_next;
    logic [addr_width-1:0]       w_addr_q;
    logic [cache_line_width-1:0] w_line_next;
    logic [cache_line_width-1:0] w_line_q;

    // Grant decision and the values to latch for the chosen owner.
    always_comb begin
        w_grant      = 1'b0;
        w_owner_next = pick_owner(petitionFromIcache, petitionFromDcache, r_last_grant);
        w_addr_next  = addrFromIcache;
        w_wflag_next = 1'b0;
        w_line_next  = '0;
        if (r_state == ST_IDLE) begin
            w_grant = petitionFromIcache | petitionFromDcache;
        end else begin
            w_grant = 1'b0;
        end
        if (w_owner_next == OWN_DCACHE) begin
            w_addr_next  = addrFromDcache;
            w_wflag_next = writeFromDcache;
            w_line_next  = lineFromDcache;
        end else begin
            w_addr_next  = addrFromIcache;
            w_wflag_next = 1'b0;
            w_line_next  = '0;
        end
    end

    assign w_done = (r_state == ST_BUSY) && (r_cnt == LAT_LAST);

    // FSM, latency counter, owner and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= OWN_ICACHE;
            r_owner      <= OWN_ICACHE;
            r_wflag      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state      <= ST_BUSY;
                        r_cnt        <= 4'd0;
                        r_last_grant <= w_owner_next;
                        r_owner      <= w_owner_next;
                        r_wflag      <= w_wflag_next;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    mem_arbiter_enreg #(.WIDTH(addr_width)) u_addr_reg (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_grant),
        .i_d     (w_addr_next),
        .o_q     (w_addr_q)
    );

    mem_arbiter_enreg #(.WIDTH(cache_line_width)) u_line_reg (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (w_grant),
        .i_d     (w_line_next),
        .o_q     (w_line_q)
    );

    // Outputs read as zero while reset is held, even mid-transaction.
    assign w_busy                = (r_state == ST_BUSY) && !reset;
    assign busy                  = w_busy;
    assign memRead               = w_busy && !r_wflag;
    assign memWrite              = w_busy && r_wflag;
    assign memServiceReadyIcache = w_done && !reset && (r_owner == OWN_ICACHE);
    assign memServiceReadyDcache = w_done && !reset && (r_owner == OWN_DCACHE);
    assign memAddr               = reset ? '0 : w_addr_q;
    assign memWriteLine          = reset ? '0 : w_line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (latency 4 and 1) share
// stimulus; a reference model queues expected transactions, a monitor checks.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          pet_i;
    logic          pet_d;
    logic          wr_d;
    logic [AW-1:0] addr_i;
    logic [AW-1:0] addr_d;
    logic [LW-1:0] line_d;

    logic [1:0]         rdy_i;
    logic [1:0]         rdy_d;
    logic [1:0]         mrd;
    logic [1:0]         mwr;
    logic [1:0]         bsy;
    logic [1:0][AW-1:0] maddr;
    logic [1:0][LW-1:0] mline;

    mem_arbiter #(.addr_width(AW), .cache_line_width(LW), .mem_latency(4)) dut0 (
        .clk(clk), .reset(reset),
        .petitionFromIcache(pet_i), .addrFromIcache(addr_i),
        .petitionFromDcache(pet_d), .addrFromDcache(addr_d),
        .writeFromDcache(wr_d), .lineFromDcache(line_d),
        .memServiceReadyIcache(rdy_i[0]), .memServiceReadyDcache(rdy_d[0]),
        .memAddr(maddr[0]), .memRead(mrd[0]), .memWrite(mwr[0]),
        .memWriteLine(mline[0]), .busy(bsy[0])
    );

    mem_arbiter #(.addr_width(AW), .cache_line_width(LW), .mem_latency(1)) dut1 (
        .clk(clk), .reset(reset),
        .petitionFromIcache(pet_i), .addrFromIcache(addr_i),
        .petitionFromDcache(pet_d), .addrFromDcache(addr_d),
        .writeFromDcache(wr_d), .lineFromDcache(line_d),
        .memServiceReadyIcache(rdy_i[1]), .memServiceReadyDcache(rdy_d[1]),
        .memAddr(maddr[1]), .memRead(mrd[1]), .memWrite(mwr[1]),
        .memWriteLine(mline[1]), .busy(bsy[1])
    );

    typedef struct {
        int            dut;
        bit            is_d;
        logic [AW-1:0] addr;
        bit            wr;
        logic [LW-1:0] line;
        int            due;
    } txn_t;

    txn_t sbq[$];

    // Reference model: per instance, busy flag plus cycles remaining.
    bit            m_busy[2];
    int            m_rem[2];
    bit            m_last_d[2];
    logic [AW-1:0] m_addr[2];
    bit            m_wr[2];
    logic [LW-1:0] m_line[2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input int d, input logic [LW-1:0] act,
                         input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit own_d;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d]   = 1'b0;
                m_rem[d]    = 0;
                m_last_d[d] = 1'b0;
                m_addr[d]   = '0;
                m_wr[d]     = 1'b0;
                m_line[d]   = '0;
            end else if (m_busy[d]) begin
                m_rem[d] = m_rem[d] - 1;
                if (m_rem[d] == 0) m_busy[d] = 1'b0;
            end else if (pet_i || pet_d) begin
                if (pet_i && pet_d) own_d = !m_last_d[d];
                else                own_d = pet_d;
                m_busy[d]   = 1'b1;
                m_rem[d]    = lat_of(d);
                m_last_d[d] = own_d;
                m_addr[d]   = own_d ? addr_d : addr_i;
                m_wr[d]     = own_d ? wr_d : 1'b0;
                m_line[d]   = own_d ? line_d : '0;
                sbq.push_back('{d, own_d, m_addr[d], m_wr[d], m_line[d], cyc + lat_of(d) - 1});
            end
        end
        if (reset) sbq.delete();
    endtask

    // Monitor: compare port state every cycle and retire transactions on ready.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                bit   exp_busy;
                bit   exp_rdy;
                int   idx;
                txn_t t;
                exp_busy = !reset && m_busy[d];
                exp_rdy  = exp_busy && (m_rem[d] == 1);
                check("busy", d, LW'(bsy[d]), LW'(exp_busy));
                check("memRead", d, LW'(mrd[d]), LW'(exp_busy && !m_wr[d]));
                check("memWrite", d, LW'(mwr[d]), LW'(exp_busy && m_wr[d]));
                check("memAddr", d, LW'(maddr[d]), reset ? '0 : LW'(m_addr[d]));
                check("memWriteLine", d, mline[d], reset ? '0 : m_line[d]);
                check("rdy_exclusive", d, LW'(rdy_i[d] & rdy_d[d]), '0);
                if (rdy_i[d] || rdy_d[d]) begin
                    idx = -1;
                    for (int k = 0; k < sbq.size(); k++) begin
                        if (idx < 0 && sbq[k].dut == d) idx = k;
                    end
                    if (idx < 0) begin
                        check("rdy_unexpected", d, LW'(1), LW'(0));
                    end else begin
                        t = sbq[idx];
                        sbq.delete(idx);
                        check("rdy_owner_d", d, LW'(rdy_d[d]), LW'(t.is_d));
                        check("rdy_cycle", d, LW'(cyc), LW'(t.due));
                        check("txn_addr", d, LW'(maddr[d]), LW'(t.addr));
                        check("txn_write", d, LW'(mwr[d]), LW'(t.wr));
                        check("txn_line", d, mline[d], t.line);
                    end
                end else if (exp_rdy) begin
                    check("rdy_missing", d, LW'(0), LW'(1));
                end
            end
        end
    end

    task automatic drive(input bit r, input bit pi, input logic [AW-1:0] ai, input bit pd,
                         input logic [AW-1:0] ad, input bit w, input logic [LW-1:0] l);
        reset  = r;
        pet_i  = pi;
        addr_i = ai;
        pet_d  = pd;
        addr_d = ad;
        wr_d   = w;
        line_d = l;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #2;
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        run(n);
    endtask

    initial begin
        logic [LW-1:0] a5_line;
        logic [LW-1:0] rl;
        a5_line = {32{8'hA5}};
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        run(3);
        idle(2);
        // Single icache fill, then a dcache write-back.
        drive(1'b0, 1'b1, 16'h0140, 1'b0, '0, 1'b0, '0);
        run(5);
        idle(3);
        drive(1'b0, 1'b0, '0, 1'b1, 16'h2200, 1'b1, a5_line);
        run(5);
        idle(3);
        // Tie right after reset: dcache first, then alternation.
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        run(2);
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 16'h3000, 1'b0, '0);
        run(14);
        idle(3);
        // Icache petition dropped mid-transaction.
        drive(1'b0, 1'b1, 16'h0400, 1'b0, '0, 1'b0, '0);
        run(2);
        idle(5);
        // Reset in cycle 2 of a dcache read, then a normal icache fill.
        drive(1'b0, 1'b0, '0, 1'b1, 16'h0800, 1'b0, '0);
        run(2);
        drive(1'b1, 1'b0, '0, 1'b1, 16'h0800, 1'b0, '0);
        run(1);
        drive(1'b0, 1'b1, 16'h0900, 1'b0, '0, 1'b0, '0);
        run(5);
        idle(3);
        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 8; k++) rl[k*32 +: 32] = $urandom();
            drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0),
                  AW'($urandom()), ($urandom_range(0, 2) != 0), AW'($urandom()),
                  $urandom_range(0, 1) == 1, rl);
            run(1);
        end
        idle(20);
        check("sb_drained", 0, LW'(sbq.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
